// File: rtl/bloom_filter_param.sv
// Bloom filter over a 104-bit 5-tuple key: lookup3-style hash, K sequential probes.
// Define BLOOM_STATS_EN to add saturating query/hit/insert counters.
module bloom_filter_param #(
  parameter int M_BITS = 256,
  parameter int K_HASH = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [1:0]   req_op,
  input  logic [103:0] req_key,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         resp_hit,
  output logic         resp_err
`ifdef BLOOM_STATS_EN
  ,
  output logic [31:0]  stat_queries,
  output logic [31:0]  stat_hits,
  output logic [31:0]  stat_inserts
`endif
);

  // state | meaning
  // IDLE  | waiting for a request, req_ready=1
  // HASH  | six hash mixing steps, one per cycle
  // PROBE | one probe index per cycle, K_HASH cycles
  // RESP  | response held until resp_ready
  typedef enum logic [1:0] {S_IDLE, S_HASH, S_PROBE, S_RESP} state_e;

  localparam int          IDX_W     = $clog2(M_BITS);
  localparam logic [1:0]  OP_QUERY  = 2'b00;
  localparam logic [1:0]  OP_INSERT = 2'b01;
  localparam logic [1:0]  OP_CLEAR  = 2'b10;
  localparam logic [1:0]  OP_RSVD   = 2'b11;
  localparam logic [2:0]  HASH_TC   = 3'd5;
  localparam logic [2:0]  PROBE_TC  = 3'(K_HASH - 1);

  function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  state_e              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [1:0]          op_q, op_d;
  logic [31:0]         a_q, a_d, b_q, b_d, c_q, c_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [M_BITS-1:0]   bits_q, bits_d;
  logic                hit_q, hit_d;
  logic                err_q, err_d;
  logic                accept;
  logic                resp_done;
  logic                is_lookup;

  assign accept    = req_valid & req_ready;
  assign resp_done = resp_valid & resp_ready;
  assign is_lookup = (req_op == OP_QUERY) || (req_op == OP_INSERT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = is_lookup ? S_HASH : S_RESP;
      S_HASH:  if (cnt_q == '0) state_d = S_PROBE;
      S_PROBE: if (cnt_q == '0) state_d = S_RESP;
      S_RESP:  if (resp_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == S_IDLE);
    resp_valid = (state_q == S_RESP);
    resp_hit   = resp_valid & hit_q;
    resp_err   = resp_valid & err_q;
  end

  always_comb begin
    cnt_d  = cnt_q;
    op_d   = op_q;
    a_d    = a_q;
    b_d    = b_q;
    c_d    = c_q;
    idx_d  = idx_q;
    bits_d = bits_q;
    hit_d  = hit_q;
    err_d  = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d  = req_op;
          a_d   = 32'hdeadbef8 + req_key[103:72];
          b_d   = 32'hdeadbef1 + req_key[71:40];
          c_d   = 32'hdeadbef8 + (req_key[39:8] ^ {24'h0, req_key[7:0]});
          cnt_d = HASH_TC;
          hit_d = is_lookup;
          err_d = (req_op == OP_RSVD);
          if (req_op == OP_CLEAR) bits_d = '0;
        end
      end
      S_HASH: begin
        case (cnt_q)
          3'd5: c_d = (c_q ^ b_q) - rotl(b_q, 14);
          3'd4: a_d = (a_q ^ c_q) - rotl(c_q, 11);
          3'd3: b_d = (b_q ^ a_q) - rotl(a_q, 25);
          3'd2: a_d = (a_q ^ c_q) - rotl(c_q, 4);
          3'd1: b_d = (b_q ^ a_q) - rotl(a_q, 14);
          3'd0: c_d = (c_q ^ b_q) - rotl(b_q, 24);
          default: ;
        endcase
        if (cnt_q == '0) begin
          idx_d = c_d[IDX_W-1:0];
          cnt_d = PROBE_TC;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_PROBE: begin
        // c_q holds h1, b_q holds b2; h2 is b2 with bit 0 forced high
        hit_d = hit_q & bits_q[idx_q];
        if (op_q == OP_INSERT) bits_d[idx_q] = 1'b1;
        idx_d = idx_q + {b_q[IDX_W-1:1], 1'b1};
        if (cnt_q != '0) cnt_d = cnt_q - 3'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      idx_q  <= '0;
      bits_q <= '0;
      hit_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      op_q   <= op_d;
      a_q    <= a_d;
      b_q    <= b_d;
      c_q    <= c_d;
      idx_q  <= idx_d;
      bits_q <= bits_d;
      hit_q  <= hit_d;
      err_q  <= err_d;
    end
  end

`ifdef BLOOM_STATS_EN
  logic [31:0] queries_q, queries_d;
  logic [31:0] hits_q, hits_d;
  logic [31:0] inserts_q, inserts_d;

  always_comb begin
    queries_d = queries_q;
    hits_d    = hits_q;
    inserts_d = inserts_q;
    if (resp_done && op_q == OP_QUERY) begin
      if (queries_q != '1) queries_d = queries_q + 32'd1;
      if (hit_q && hits_q != '1) hits_d = hits_q + 32'd1;
    end
    if (resp_done && op_q == OP_INSERT && inserts_q != '1) inserts_d = inserts_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      queries_q <= '0;
      hits_q    <= '0;
      inserts_q <= '0;
    end else begin
      queries_q <= queries_d;
      hits_q    <= hits_d;
      inserts_q <= inserts_d;
    end
  end

  assign stat_queries = queries_q;
  assign stat_hits    = hits_q;
  assign stat_inserts = inserts_q;
`endif

endmodule

// File: doc/bloom_filter_param.md
BLOOM_FILTER_PARAM -- requirements
Module: bloom_filter_param

Interface
REQ-001 Parameter M_BITS, default 256: bloom bit-array size; power of two, 8..4096.
REQ-002 Parameter K_HASH, default 3: probe indices per key, 1..8.
REQ-003 Port clk  in  1: single clock; all state on rising edge.
REQ-004 Port reset_n  in  1: asynchronous, active-low reset.
REQ-005 Port req_valid  in  1: request present.
REQ-006 Port req_ready  out  1: block can accept a request.
REQ-007 Port req_op  in  2: 00 query, 01 insert, 10 clear, 11 reserved.
REQ-008 Port req_key  in  104: {src_ip[31:0], dst_ip[31:0], protocol[7:0], src_port[15:0], dst_port[15:0]}, MSB first.
REQ-009 Port resp_valid  out  1: response present.
REQ-010 Port resp_ready  in  1: consumer accepts response.
REQ-011 Port resp_hit  out  1: query: all K probed bits set; insert: all K bits were already set before the insert; else 0.
REQ-012 Port resp_err  out  1: request used reserved op 11.

Function
REQ-013 Request handshake SHALL complete on an edge with req_valid=1 and req_ready=1; req_op and req_key SHALL be captured then; later input changes SHALL be ignored.
REQ-014 req_ready SHALL be 1 only in state IDLE.
REQ-015 FSM states: IDLE, HASH, PROBE, RESP. IDLE->HASH on query/insert accept; IDLE->RESP on clear or reserved accept; HASH->PROBE after 6 cycles; PROBE->RESP after K_HASH cycles; RESP->IDLE on resp_valid=1 and resp_ready=1.
REQ-016 Hash seed, 32-bit modulo arithmetic: a0=0xdeadbef8+key[103:72]; b0=0xdeadbef1+key[71:40]; c0=0xdeadbef8+(key[39:8] XOR {24'h0,key[7:0]}).
REQ-017 HASH SHALL compute one step per cycle, rotl(x,n) = 32-bit rotate left by n: c1=(c0^b0)-rotl(b0,14); a1=(a0^c1)-rotl(c1,11); b1=(b0^a1)-rotl(a1,25); a2=(a1^c1)-rotl(c1,4); b2=(b1^a2)-rotl(a2,14); h1=(c1^b2)-rotl(b2,24).
REQ-018 h2 SHALL equal b2 with bit 0 forced to 1; probe index i (0..K_HASH-1) SHALL be (h1 + i*h2) mod M_BITS, taken as the low log2(M_BITS) bits.
REQ-019 PROBE SHALL handle one index per cycle, in order i=0..K_HASH-1, and SHALL AND the read bit into the hit accumulator; for insert, the bit SHALL be set in the same cycle it is read.
REQ-020 Duplicate indices within one key SHALL be legal; an insert SHALL read the value held before this request's write.
REQ-021 Latency: resp_valid SHALL rise 6+K_HASH cycles after the accept edge for query/insert, and 1 cycle after it for clear and reserved.
REQ-022 Clear SHALL zero all M_BITS bits on the cycle after accept; resp_hit=0, resp_err=0.
REQ-023 Reserved op SHALL leave the array unchanged; resp_err=1, resp_hit=0.
REQ-024 In RESP, resp_hit and resp_err SHALL stay stable until the response handshake completes; resp_ready is ignored outside RESP.
REQ-025 No request SHALL be accepted on the edge on which a response completes; IDLE lasts at least 1 cycle.

Reset
REQ-026 reset_n=0 SHALL immediately force: state IDLE, all bit-array bits 0, resp_valid=0, resp_hit=0, resp_err=0, hash registers 0; req_ready=1 after deassertion.
REQ-027 Reset during HASH, PROBE or RESP SHALL abort the operation with no response; partial insert writes SHALL be lost in the array clear.

Configuration
REQ-028 Macro BLOOM_STATS_EN defined: add outputs stat_queries, stat_hits, stat_inserts, 32 bits each. Each counter increments once per completed query, query with hit=1, or completed insert, and saturates at 0xFFFFFFFF. Counters are zeroed by reset only; clear does not affect them.
REQ-029 Macro BLOOM_STATS_EN undefined: those ports and counters SHALL be absent; all other behaviour is identical.

Verification (M_BITS=256, K_HASH=3, key A = {192.169.1.30, 192.168.1.30, 8'd30, 16'd16538, 16'd37281})
REQ-030 Reset, query A -> resp_valid exactly 9 cycles after accept, resp_hit=0, resp_err=0.
REQ-031 Insert A (resp_hit=0), then query A -> resp_hit=1; then a second insert A -> resp_hit=1.
REQ-032 Insert A, clear (resp_valid 1 cycle after accept), query A -> resp_hit=0.
REQ-033 Query A with resp_ready held 0 for 5 cycles in RESP -> resp_valid/resp_hit stable and req_ready=0 throughout; IDLE one cycle after handshake.
REQ-034 op=11 after insert A -> resp_err=1, resp_hit=0; following query A -> resp_hit=1.
REQ-035 Pulse reset_n low during PROBE of insert A -> no response, req_ready=1 after release; query A -> resp_hit=0; with BLOOM_STATS_EN all stat counters read 0.
